// File: rtl/ssi_position_tracker.sv
// ssi_position_tracker
// Turns the SSI reader's absolute angle words into a signed multi-turn
// position and a windowed velocity. Glitches (oversized jumps) and
// magnet-field errors are rejected; GLITCH_LIMIT rejects in a row latch FAULT.
//
// state  | meaning
// -------+--------------------------------------------------------------
// INIT   | waiting for a good sample to seed position and prev_angle
// TRACK  | unwrapping deltas, accumulating velocity, counting rejects
// FAULT  | too many consecutive rejects; samples ignored until clear_fault
module ssi_position_tracker #(
    parameter int RES          = 10,
    parameter int POS_W        = 32,
    parameter int VEL_W        = 16,
    parameter int MAX_STEP     = 128,
    parameter int GLITCH_LIMIT = 3,
    parameter int VEL_WINDOW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RES-1:0]   angle_in,
    input  logic             angle_valid,
    input  logic             mag_high,
    input  logic             mag_low,
    input  logic             clear_fault,
    output logic [POS_W-1:0] position,
    output logic [VEL_W-1:0] velocity,
    output logic             pos_valid,
    output logic             vel_valid,
    output logic             fault,
    output logic [1:0]       state
);

    localparam int GW = $clog2(GLITCH_LIMIT + 1);
    localparam int WW = $clog2(VEL_WINDOW + 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_LIMIT - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(VEL_WINDOW - 1);
    localparam logic signed [31:0] VEL_MAX = 32'((2 ** (VEL_W - 1)) - 1);
    localparam logic signed [31:0] VEL_MIN = -32'(2 ** (VEL_W - 1));
    localparam logic [RES-1:0] HALF_TURN = {1'b1, {(RES-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              st;
    logic [RES-1:0]      prev_angle;
    logic [GW-1:0]       glitch_cnt;
    logic [WW-1:0]       win_cnt;
    logic signed [31:0]  vel_acc;

    logic [RES-1:0]      diff;
    logic signed [31:0]  delta;
    logic [POS_W-1:0]    pos_step;
    logic                sample_good;
    logic                accept;
    logic signed [31:0]  vel_sum;
    logic [VEL_W-1:0]    vel_sat;

    assign state = st;

    // Modular angle difference, acceptance test and saturated window sum
    always_comb begin
        diff        = angle_in - prev_angle;
        delta       = {{(32-RES){diff[RES-1]}}, diff};
        pos_step    = {{(POS_W-RES){diff[RES-1]}}, diff};
        sample_good = !(mag_high || mag_low);
        // A half-turn jump has no defined direction, so it never counts as motion
        accept      = sample_good && (diff != HALF_TURN) &&
                      (delta <= MAX_STEP) && (delta >= -MAX_STEP);
        vel_sum     = accept ? (vel_acc + delta) : vel_acc;
        if (vel_sum > VEL_MAX) begin
            vel_sat = VEL_MAX[VEL_W-1:0];
        end else if (vel_sum < VEL_MIN) begin
            vel_sat = VEL_MIN[VEL_W-1:0];
        end else begin
            vel_sat = vel_sum[VEL_W-1:0];
        end
    end

    // Tracking FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_INIT;
            position   <= '0;
            velocity   <= '0;
            pos_valid  <= 1'b0;
            vel_valid  <= 1'b0;
            fault      <= 1'b0;
            prev_angle <= '0;
            glitch_cnt <= '0;
            win_cnt    <= '0;
            vel_acc    <= '0;
        end else begin
            pos_valid <= 1'b0;
            vel_valid <= 1'b0;
            case (st)
                ST_INIT: begin
                    if (angle_valid && sample_good) begin
                        prev_angle <= angle_in;
                        position   <= {{(POS_W-RES){1'b0}}, angle_in};
                        pos_valid  <= 1'b1;
                        st         <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (angle_valid) begin
                        if (accept) begin
                            position   <= position + pos_step;
                            prev_angle <= angle_in;
                            glitch_cnt <= '0;
                            pos_valid  <= 1'b1;
                        end else begin
                            glitch_cnt <= glitch_cnt + 1'b1;
                        end
                        if (win_cnt == WIN_LAST) begin
                            velocity  <= vel_sat;
                            vel_valid <= 1'b1;
                            vel_acc   <= '0;
                            win_cnt   <= '0;
                        end else begin
                            vel_acc   <= vel_sum;
                            win_cnt   <= win_cnt + 1'b1;
                        end
                        // Last tolerated reject: latch FAULT and drop partial window
                        if (!accept && (glitch_cnt == GLITCH_LAST)) begin
                            st         <= ST_FAULT;
                            fault      <= 1'b1;
                            glitch_cnt <= '0;
                            win_cnt    <= '0;
                            vel_acc    <= '0;
                        end
                    end
                end
                ST_FAULT: begin
                    glitch_cnt <= '0;
                    win_cnt    <= '0;
                    vel_acc    <= '0;
                    if (clear_fault) begin
                        st    <= ST_INIT;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    st <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssi_position_tracker.sv
// Bench for ssi_position_tracker: directed scenarios plus a randomized run,
// checked against an arithmetic reference model and a pulse scoreboard.
module tb_ssi_position_tracker;

    localparam int RES = 10;
    localparam int POS_W = 32;
    localparam int VEL_W = 16;
    localparam int MAX_STEP = 128;
    localparam int GLITCH_LIMIT = 3;
    localparam int VEL_WINDOW = 8;
    localparam int TURN = 1 << RES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [RES-1:0]   angle_in = '0;
    logic             angle_valid = 1'b0;
    logic             mag_high = 1'b0;
    logic             mag_low = 1'b0;
    logic             clear_fault = 1'b0;
    logic [POS_W-1:0] position;
    logic [VEL_W-1:0] velocity;
    logic             pos_valid;
    logic             vel_valid;
    logic             fault;
    logic [1:0]       state;

    ssi_position_tracker #(
        .RES(RES), .POS_W(POS_W), .VEL_W(VEL_W), .MAX_STEP(MAX_STEP),
        .GLITCH_LIMIT(GLITCH_LIMIT), .VEL_WINDOW(VEL_WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .angle_in(angle_in), .angle_valid(angle_valid),
        .mag_high(mag_high), .mag_low(mag_low), .clear_fault(clear_fault),
        .position(position), .velocity(velocity), .pos_valid(pos_valid),
        .vel_valid(vel_valid), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    // reference model: 0=INIT 1=TRACK 2=FAULT
    int         m_st = 0;
    bit [31:0]  m_pos = 0;
    int         m_vel = 0;
    int         m_prev = 0;
    int         m_glitch = 0;
    int         m_win = 0;
    int         m_acc = 0;

    typedef struct {
        bit        pv;
        bit        vv;
        bit [31:0] pos;
        bit [15:0] vel;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_vel(input int x);
        int hi = (1 << (VEL_W - 1)) - 1;
        int lo = -(1 << (VEL_W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_update(input bit v, input int a, input bit mh, input bit ml,
                                input bit cf, input bit r);
        bit pv = 0;
        bit vv = 0;
        bit good = !(mh || ml);
        if (r) begin
            m_st = 0; m_pos = 0; m_vel = 0; m_prev = 0;
            m_glitch = 0; m_win = 0; m_acc = 0;
        end else if (m_st == 0) begin
            if (v && good) begin
                m_prev = a; m_pos = 32'(a); pv = 1; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (v) begin
                int d;
                bit ok;
                d = (a - m_prev + TURN) % TURN;
                if (d >= TURN / 2) d = d - TURN;
                ok = good && (d != -(TURN / 2)) && (d <= MAX_STEP) && (d >= -MAX_STEP);
                if (ok) begin
                    m_pos = m_pos + 32'(d);
                    m_prev = a;
                    m_glitch = 0;
                    m_acc = m_acc + d;
                    pv = 1;
                end else begin
                    m_glitch++;
                end
                m_win++;
                if (m_win == VEL_WINDOW) begin
                    m_vel = sat_vel(m_acc);
                    vv = 1;
                    m_acc = 0;
                    m_win = 0;
                end
                if (!ok && m_glitch >= GLITCH_LIMIT) begin
                    m_st = 2; m_glitch = 0; m_win = 0; m_acc = 0;
                end
            end
        end else begin
            m_glitch = 0; m_win = 0; m_acc = 0;
            if (cf) m_st = 0;
        end
        if (pv || vv) exp_q.push_back('{pv, vv, m_pos, m_vel[15:0]});
    endtask

    // One clock: drive inputs, let the DUT and model both take the edge
    task automatic step(input bit v, input int a, input bit mh, input bit ml,
                        input bit cf, input bit r);
        angle_valid = v;
        angle_in    = RES'(a);
        mag_high    = mh;
        mag_low     = ml;
        clear_fault = cf;
        rst         = r;
        @(posedge clk);
        model_update(v, a, mh, ml, cf, r);
        #1;
        angle_valid = 0; mag_high = 0; mag_low = 0; clear_fault = 0; rst = 0;
    endtask

    task automatic strobe(input int a);
        step(1, a, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: registers vs model every cycle, pulses vs scoreboard queue
    always @(negedge clk) begin
        if (mon_en) begin
            check("state", state, m_st);
            check("fault", fault, (m_st == 2));
            check("position", position, m_pos);
            check("velocity", velocity, m_vel & 32'hFFFF);
            if (pos_valid || vel_valid || exp_q.size() > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {pos_valid, vel_valid}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pos_valid", pos_valid, e.pv);
                    check("sb_vel_valid", vel_valid, e.vv);
                    if (e.pv) check("sb_position", position, e.pos);
                    if (e.vv) check("sb_velocity", velocity, e.vel);
                end
            end
        end
    end

    initial begin
        do_reset();
        mon_en = 1;
        check("rst_state", state, 0);
        check("rst_position", position, 0);
        check("rst_pulses", {pos_valid, vel_valid, fault}, 0);

        // 1: seed
        strobe(100);
        check("t1_pos", position, 100);
        check("t1_pos_valid", pos_valid, 1);
        check("t1_state", state, 1);
        check("t1_vel", velocity, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t1_pulse_width", pos_valid, 0);

        // 2: wrap both ways
        do_reset();
        strobe(1020);
        strobe(1023);
        check("t2_pos_a", position, 1023);
        strobe(3);
        check("t2_pos_b", position, 1027);
        strobe(1021);
        check("t2_pos_c", position, 1021);

        // 3: full velocity window
        do_reset();
        strobe(0);
        for (int i = 1; i <= 8; i++) begin
            strobe(5 * i);
            if (i < 8) check("t3_no_early_vel", vel_valid, 0);
        end
        check("t3_pos", position, 40);
        check("t3_vel", velocity, 40);
        check("t3_vel_valid", vel_valid, 1);
        strobe(45);
        check("t3_9th_vel_valid", vel_valid, 0);

        // 4: glitch reject then fault
        do_reset();
        strobe(200);
        strobe(500);
        check("t4_rej_pv", pos_valid, 0);
        check("t4_rej_pos", position, 200);
        strobe(210);
        check("t4_acc_pos", position, 210);
        for (int i = 0; i < 3; i++) strobe(700);
        check("t4_fault", fault, 1);
        check("t4_state", state, 2);

        // boundary: +/-MAX_STEP accepted, MAX_STEP+1 rejected
        do_reset();
        strobe(500);
        strobe(628);
        check("bnd_plus_max", position, 628);
        strobe(500);
        check("bnd_minus_max", position, 500);
        strobe(629);
        check("bnd_over_max_pv", pos_valid, 0);
        check("bnd_over_max_pos", position, 500);

        // 5: magnet error, fault, clear
        do_reset();
        strobe(300);
        step(1, 305, 0, 1, 0, 0);
        check("t5_mag_pv", pos_valid, 0);
        check("t5_mag_pos", position, 300);
        step(1, 305, 1, 0, 0, 0);
        step(1, 305, 0, 1, 0, 0);
        check("t5_fault_state", state, 2);
        step(1, 77, 0, 0, 1, 0);
        check("t5_clear_state", state, 0);
        check("t5_clear_drops", pos_valid, 0);
        check("t5_hold_pos", position, 300);
        step(1, 60, 1, 0, 0, 0);
        check("t5_init_bad_ignored", state, 0);
        strobe(50);
        check("t5_reseed", position, 50);
        check("t5_state_track", state, 1);
        step(0, 0, 0, 0, 1, 0);
        check("t5_clear_in_track", state, 1);

        // 6: reset mid-window
        do_reset();
        strobe(10);
        for (int i = 1; i <= 8; i++) strobe(10 + 3 * i);
        check("t6_vel_pre", velocity, 24);
        for (int i = 1; i <= 3; i++) strobe(34 + i);
        step(0, 0, 0, 0, 0, 1);
        check("t6_rst_pos", position, 0);
        check("t6_rst_vel", velocity, 0);
        check("t6_rst_flags", {pos_valid, vel_valid, fault}, 0);
        check("t6_rst_state", state, 0);
        strobe(20);
        for (int i = 1; i <= 8; i++) begin
            strobe(20 + i);
            check("t6_window_vv", vel_valid, (i == 8));
        end

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int sel;
            int d;
            int a;
            bit r;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                a = $urandom_range(0, TURN - 1);
            end else begin
                if (sel == 1) begin
                    case ($urandom_range(0, 4))
                        0: d = MAX_STEP;
                        1: d = -MAX_STEP;
                        2: d = MAX_STEP + 1;
                        3: d = -MAX_STEP - 1;
                        default: d = TURN / 2;
                    endcase
                end else begin
                    d = $urandom_range(0, 280) - 140;
                end
                a = (m_prev + d + 2 * TURN) % TURN;
            end
            r = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 2) != 0, a, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0, r);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
